// File: rtl/l2_port_arbiter_pkg.sv
// l2_arb_types: shared types and default widths for the L2 port arbiter.
//   arb_state_e : arbiter FSM states (also exported on the debug state output)
//   req_e       : requester identity, used to remember the last grant
package l2_arb_types;

  localparam int ADDR_WIDTH_DEF = 32;
  localparam int LINE_WIDTH_DEF = 256;
  localparam int CNT_WIDTH_DEF  = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SERVE_I = 3'd1,
    SERVE_D = 3'd2,
    RESP_I  = 3'd3,
    RESP_D  = 3'd4
  } arb_state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_e;

endpackage

// File: rtl/l2_port_arbiter_if.sv
// l2_port_arbiter_if: all request, response, L2 and status signals of the
// L2 port arbiter.
//   master modport : the arbiter's view (drives responses, L2 strobes, status)
//   slave modport  : the environment's view (L1 controllers and L2 cache)
//
// Handshake: a requester raises *_pmem_read / d_pmem_write and holds it,
// with address/data stable, until it sees its one-cycle *_pmem_resp; read
// data is valid only in that cycle. On the L2 side l2_read / l2_write are
// held with a stable address/wdata until the L2 returns a one-cycle
// l2_mem_resp, with l2_rdata valid in that same cycle.
interface l2_port_arbiter_if
  import l2_arb_types::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int LINE_WIDTH = LINE_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
);
  logic                  i_pmem_read;
  logic [ADDR_WIDTH-1:0] i_pmem_address;
  logic [LINE_WIDTH-1:0] i_pmem_rdata;
  logic                  i_pmem_resp;

  logic                  d_pmem_read;
  logic                  d_pmem_write;
  logic [ADDR_WIDTH-1:0] d_pmem_address;
  logic [LINE_WIDTH-1:0] d_pmem_wdata;
  logic [LINE_WIDTH-1:0] d_pmem_rdata;
  logic                  d_pmem_resp;

  logic                  l2_read;
  logic                  l2_write;
  logic [ADDR_WIDTH-1:0] l2_address;
  logic [LINE_WIDTH-1:0] l2_wdata;
  logic [LINE_WIDTH-1:0] l2_rdata;
  logic                  l2_mem_resp;

  logic                  grant_d;
  logic                  busy;
  logic [CNT_WIDTH-1:0]  contention_count;
  arb_state_e            dbg_state;

  modport master (
    input  i_pmem_read, i_pmem_address,
    output i_pmem_rdata, i_pmem_resp,
    input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    output d_pmem_rdata, d_pmem_resp,
    output l2_read, l2_write, l2_address, l2_wdata,
    input  l2_rdata, l2_mem_resp,
    output grant_d, busy, contention_count, dbg_state
  );

  modport slave (
    output i_pmem_read, i_pmem_address,
    input  i_pmem_rdata, i_pmem_resp,
    output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    input  d_pmem_rdata, d_pmem_resp,
    input  l2_read, l2_write, l2_address, l2_wdata,
    output l2_rdata, l2_mem_resp,
    input  grant_d, busy, contention_count, dbg_state
  );

endinterface

// File: rtl/l2_port_arbiter_sat_counter.sv
// sat_counter: saturating up-counter.
//   clk   : clock
//   clr   : synchronous clear (highest priority)
//   inc   : add one this cycle unless already all-ones
//   count : current value
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter: round-robin arbiter for the single L2 port shared by the
// I-cache fill path and the D-cache fill/writeback path.
//   clk, rst : clock, synchronous active-high reset
//   bus      : l2_port_arbiter_if.master -- requester ports, L2 port,
//              status (grant_d, busy), contention_count and dbg_state
// The winner's address/wdata/type are latched at grant, so requesters may
// change their inputs while being served. A RESP cycle always follows SERVE
// so a request still held during its response pulse is not re-arbitrated.
module l2_port_arbiter
  import l2_arb_types::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int LINE_WIDTH = LINE_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int D_FIRST    = 1
) (
  input logic               clk,
  input logic               rst,
  l2_port_arbiter_if.master bus
);

  arb_state_e            state;
  req_e                  last_grant;
  logic                  lat_write;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [LINE_WIDTH-1:0] lat_wdata;
  logic [LINE_WIDTH-1:0] i_line;
  logic [LINE_WIDTH-1:0] d_line;
  logic                  l2_read_q;
  logic                  l2_write_q;
  logic                  i_resp_q;
  logic                  d_resp_q;
  logic                  grant_d_q;
  logic                  busy_q;
  logic                  d_req;
  logic                  i_req;
  logic                  d_wins;
  logic                  cont_inc;
  logic [CNT_WIDTH-1:0]  cont_count;

  assign d_req  = bus.d_pmem_read | bus.d_pmem_write;
  assign i_req  = bus.i_pmem_read;
  // D wins when alone, or on a tie when I was granted last.
  assign d_wins = d_req && (!i_req || (last_grant == REQ_I));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= (D_FIRST != 0) ? REQ_I : REQ_D;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      i_line     <= '0;
      d_line     <= '0;
      l2_read_q  <= 1'b0;
      l2_write_q <= 1'b0;
      i_resp_q   <= 1'b0;
      d_resp_q   <= 1'b0;
      grant_d_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (d_wins) begin
            state      <= SERVE_D;
            last_grant <= REQ_D;
            lat_addr   <= bus.d_pmem_address;
            lat_wdata  <= bus.d_pmem_wdata;
            // Write has precedence if both read and write are raised.
            lat_write  <= bus.d_pmem_write;
            l2_read_q  <= ~bus.d_pmem_write;
            l2_write_q <= bus.d_pmem_write;
            grant_d_q  <= 1'b1;
            busy_q     <= 1'b1;
          end else if (i_req) begin
            state      <= SERVE_I;
            last_grant <= REQ_I;
            lat_addr   <= bus.i_pmem_address;
            lat_write  <= 1'b0;
            l2_read_q  <= 1'b1;
            l2_write_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        SERVE_I, SERVE_D: begin
          if (bus.l2_mem_resp) begin
            l2_read_q  <= 1'b0;
            l2_write_q <= 1'b0;
            if (state == SERVE_D) begin
              state    <= RESP_D;
              d_line   <= bus.l2_rdata;
              d_resp_q <= 1'b1;
            end else begin
              state    <= RESP_I;
              i_line   <= bus.l2_rdata;
              i_resp_q <= 1'b1;
            end
          end
        end
        RESP_I, RESP_D: begin
          state     <= IDLE;
          i_resp_q  <= 1'b0;
          d_resp_q  <= 1'b0;
          grant_d_q <= 1'b0;
          busy_q    <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          l2_read_q  <= 1'b0;
          l2_write_q <= 1'b0;
          i_resp_q   <= 1'b0;
          d_resp_q   <= 1'b0;
          grant_d_q  <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  // A requester is waiting when it is pending but not the one being served;
  // in IDLE that only happens on a tie (the loser waits).
  always_comb begin
    cont_inc = 1'b0;
    case (state)
      IDLE:            cont_inc = d_req & i_req;
      SERVE_I, RESP_I: cont_inc = d_req;
      SERVE_D, RESP_D: cont_inc = i_req;
      default:         cont_inc = 1'b0;
    endcase
  end

  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_contention (
    .clk  (clk),
    .clr  (rst),
    .inc  (cont_inc),
    .count(cont_count)
  );

  assign bus.i_pmem_rdata     = i_line;
  assign bus.i_pmem_resp      = i_resp_q;
  assign bus.d_pmem_rdata     = d_line;
  assign bus.d_pmem_resp      = d_resp_q;
  assign bus.l2_read          = l2_read_q;
  assign bus.l2_write         = l2_write_q;
  assign bus.l2_address       = lat_addr;
  assign bus.l2_wdata         = lat_wdata;
  assign bus.grant_d          = grant_d_q;
  assign bus.busy             = busy_q;
  assign bus.contention_count = cont_count;
  assign bus.dbg_state        = state;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// tb_l2_port_arbiter: directed test of l2_port_arbiter against a
// transaction-phase model (idle / serving / responding per owner).
module tb_l2_port_arbiter;
  import l2_arb_types::*;

  localparam int AW   = 32;
  localparam int LW   = 256;
  localparam int CW   = 4;
  localparam int DF   = 1;
  localparam int CMAX = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  l2_port_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .CNT_WIDTH(CW)) bus ();

  l2_port_arbiter #(
    .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .CNT_WIDTH(CW), .D_FIRST(DF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 = nobody owns L2, 1 = owner's L2 transfer in flight,
  //        2 = owner's response cycle
  int            m_phase = 0;
  bit            m_owner_d = 1'b0;
  bit            m_wr = 1'b0;
  bit            m_prefer_d = 1'b1;
  logic [AW-1:0] m_addr = '0;
  logic [LW-1:0] m_wdata = '0;
  logic [LW-1:0] m_irdata = '0;
  logic [LW-1:0] m_drdata = '0;
  int            m_cnt = 0;

  logic d_req, i_req;
  assign d_req = bus.d_pmem_read | bus.d_pmem_write;
  assign i_req = bus.i_pmem_read;

  function automatic int waiting_now();
    if (m_phase == 0) return (d_req && i_req) ? 1 : 0;
    return (m_owner_d ? i_req : d_req) ? 1 : 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase    <= 0;
      m_prefer_d <= (DF != 0);
      m_cnt      <= 0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_irdata   <= '0;
      m_drdata   <= '0;
      m_wr       <= 1'b0;
      m_owner_d  <= 1'b0;
    end else begin
      m_cnt <= (m_cnt + waiting_now() > CMAX) ? CMAX : m_cnt + waiting_now();
      case (m_phase)
        0: begin
          if (d_req && (!i_req || m_prefer_d)) begin
            m_phase    <= 1;
            m_owner_d  <= 1'b1;
            m_prefer_d <= 1'b0;
            m_addr     <= bus.d_pmem_address;
            m_wdata    <= bus.d_pmem_wdata;
            m_wr       <= bus.d_pmem_write;
          end else if (i_req) begin
            m_phase    <= 1;
            m_owner_d  <= 1'b0;
            m_prefer_d <= 1'b1;
            m_addr     <= bus.i_pmem_address;
            m_wr       <= 1'b0;
          end
        end
        1: begin
          if (bus.l2_mem_resp) begin
            m_phase <= 2;
            if (m_owner_d) m_drdata <= bus.l2_rdata;
            else           m_irdata <= bus.l2_rdata;
          end
        end
        default: m_phase <= 0;
      endcase
    end
  end

  // ---------------- per-cycle compare + grant log ----------------
  bit   dut_grants[$];
  logic prev_busy = 1'b0;

  always @(negedge clk) begin
    if (check_en) begin
      chk("l2_read",    LW'(bus.l2_read),     LW'(m_phase == 1 && !m_wr));
      chk("l2_write",   LW'(bus.l2_write),    LW'(m_phase == 1 && m_wr));
      chk("l2_address", LW'(bus.l2_address),  LW'(m_addr));
      chk("l2_wdata",   bus.l2_wdata,         m_wdata);
      chk("i_resp",     LW'(bus.i_pmem_resp), LW'(m_phase == 2 && !m_owner_d));
      chk("d_resp",     LW'(bus.d_pmem_resp), LW'(m_phase == 2 && m_owner_d));
      chk("i_rdata",    bus.i_pmem_rdata,     m_irdata);
      chk("d_rdata",    bus.d_pmem_rdata,     m_drdata);
      chk("grant_d",    LW'(bus.grant_d),     LW'(m_phase != 0 && m_owner_d));
      chk("busy",       LW'(bus.busy),        LW'(m_phase != 0));
      chk("idle_state", LW'(bus.dbg_state == IDLE), LW'(m_phase == 0));
      chk("contention", LW'(bus.contention_count), LW'(m_cnt));
      if (bus.busy && !prev_busy) dut_grants.push_back(bus.grant_d);
    end
    prev_busy <= bus.busy;
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_strobe();
    bit ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.l2_read || bus.l2_write) begin
        ok = 1'b1;
        break;
      end
    end
    chk("strobe_timeout", LW'(ok), LW'(1'b1));
  endtask

  // Answer the next L2 strobe 'dly' cycles after it is seen; returns at the
  // negedge of the response cycle, optionally dropping the served request.
  task automatic l2_reply(input int dly, input logic [LW-1:0] data, input bit drop);
    wait_strobe();
    repeat (dly - 1) @(negedge clk);
    bus.l2_rdata    = data;
    bus.l2_mem_resp = 1'b1;
    @(negedge clk);
    bus.l2_mem_resp = 1'b0;
    bus.l2_rdata    = '0;
    if (drop) begin
      if (bus.i_pmem_resp) bus.i_pmem_read = 1'b0;
      if (bus.d_pmem_resp) begin
        bus.d_pmem_read  = 1'b0;
        bus.d_pmem_write = 1'b0;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic [LW-1:0] line_aa, line_wr, line_55;
    line_aa = {32{8'hAA}};
    line_wr = {8{32'h1234_5678}};
    line_55 = {32{8'h55}};

    bus.i_pmem_read    = 1'b0;
    bus.i_pmem_address = '0;
    bus.d_pmem_read    = 1'b0;
    bus.d_pmem_write   = 1'b0;
    bus.d_pmem_address = '0;
    bus.d_pmem_wdata   = '0;
    bus.l2_rdata       = '0;
    bus.l2_mem_resp    = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_en = 1'b1;

    // Reset state, literal values
    chk("rst_busy", LW'(bus.busy), LW'(1'b0));
    chk("rst_cnt",  LW'(bus.contention_count), LW'(0));
    chk("rst_addr", LW'(bus.l2_address), LW'(0));
    chk("rst_resp", LW'(bus.i_pmem_resp | bus.d_pmem_resp), LW'(1'b0));

    // Single I fill
    @(negedge clk);
    bus.i_pmem_address = 32'h0000_1040;
    bus.i_pmem_read    = 1'b1;
    l2_reply(4, line_aa, 1'b1);
    chk("t1_addr",  LW'(bus.l2_address), LW'(32'h0000_1040));
    chk("t1_resp",  LW'(bus.i_pmem_resp), LW'(1'b1));
    chk("t1_dresp", LW'(bus.d_pmem_resp), LW'(1'b0));
    chk("t1_rdata", bus.i_pmem_rdata, line_aa);
    chk("t1_cnt",   LW'(bus.contention_count), LW'(0));
    @(negedge clk);
    chk("t1_once",  LW'(bus.i_pmem_resp), LW'(1'b0));

    // Continuous tie after reset: D, I, D, I
    do_reset();
    dut_grants.delete();
    bus.i_pmem_address = 32'h0000_0100;
    bus.d_pmem_address = 32'h0000_0200;
    bus.i_pmem_read    = 1'b1;
    bus.d_pmem_read    = 1'b1;
    for (int r = 0; r < 4; r++) begin
      l2_reply(2, LW'(r + 1), 1'b0);
    end
    bus.i_pmem_read = 1'b0;
    bus.d_pmem_read = 1'b0;
    @(negedge clk);
    chk("tie_count", LW'(dut_grants.size()), LW'(4));
    if (dut_grants.size() == 4) begin
      chk("tie_g0", LW'(dut_grants[0]), LW'(1'b1));
      chk("tie_g1", LW'(dut_grants[1]), LW'(1'b0));
      chk("tie_g2", LW'(dut_grants[2]), LW'(1'b1));
      chk("tie_g3", LW'(dut_grants[3]), LW'(1'b0));
    end
    chk("tie_d_rdata", bus.d_pmem_rdata, LW'(3));
    chk("tie_i_rdata", bus.i_pmem_rdata, LW'(4));

    // D writeback with read also raised; inputs change while served
    @(negedge clk);
    bus.d_pmem_address = 32'h0000_2000;
    bus.d_pmem_wdata   = line_wr;
    bus.d_pmem_read    = 1'b1;
    bus.d_pmem_write   = 1'b1;
    wait_strobe();
    chk("wb_write", LW'(bus.l2_write), LW'(1'b1));
    chk("wb_read",  LW'(bus.l2_read), LW'(1'b0));
    bus.d_pmem_address = 32'hDEAD_0000;
    bus.d_pmem_wdata   = '1;
    repeat (2) @(negedge clk);
    chk("wb_addr",  LW'(bus.l2_address), LW'(32'h0000_2000));
    chk("wb_wdata", bus.l2_wdata, line_wr);
    bus.l2_mem_resp = 1'b1;
    @(negedge clk);
    bus.l2_mem_resp  = 1'b0;
    chk("wb_resp", LW'(bus.d_pmem_resp), LW'(1'b1));
    bus.d_pmem_read  = 1'b0;
    bus.d_pmem_write = 1'b0;
    @(negedge clk);
    chk("wb_once", LW'(bus.d_pmem_resp), LW'(1'b0));

    // Contention saturation: I waits through a long D service
    do_reset();
    bus.i_pmem_read = 1'b1;
    bus.d_pmem_read = 1'b1;
    l2_reply(20, line_55, 1'b1);
    chk("sat_cnt",  LW'(bus.contention_count), LW'(15));
    l2_reply(1, line_aa, 1'b1);
    chk("sat_hold", LW'(bus.contention_count), LW'(15));

    // Reset in SERVE_D, then a late L2 response
    do_reset();
    bus.d_pmem_address = 32'h0000_3000;
    bus.d_pmem_write   = 1'b1;
    wait_strobe();
    @(negedge clk);
    rst = 1'b1;
    bus.d_pmem_write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_l2w",  LW'(bus.l2_write), LW'(1'b0));
    chk("mid_idle", LW'(bus.dbg_state == IDLE), LW'(1'b1));
    chk("mid_resp", LW'(bus.d_pmem_resp), LW'(1'b0));
    chk("mid_cnt",  LW'(bus.contention_count), LW'(0));
    bus.l2_rdata    = line_55;
    bus.l2_mem_resp = 1'b1;
    @(negedge clk);
    bus.l2_mem_resp = 1'b0;
    bus.l2_rdata    = '0;
    chk("late_resp",  LW'(bus.d_pmem_resp | bus.i_pmem_resp), LW'(1'b0));
    chk("late_rdata", bus.d_pmem_rdata, LW'(0));

    // Spurious L2 response in IDLE
    repeat (2) @(negedge clk);
    bus.l2_rdata    = line_aa;
    bus.l2_mem_resp = 1'b1;
    @(negedge clk);
    bus.l2_mem_resp = 1'b0;
    bus.l2_rdata    = '0;
    repeat (2) @(negedge clk);
    chk("spur_busy", LW'(bus.busy), LW'(1'b0));
    chk("spur_resp", LW'(bus.d_pmem_resp | bus.i_pmem_resp), LW'(1'b0));
    chk("spur_rdata", bus.i_pmem_rdata, LW'(0));

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/l2_port_arbiter.md
Name: l2_port_arbiter

Overview:
Arbitrates the single L2 memory port between the I-cache miss path and the D-cache miss/writeback path. Grant is registered and round-robin. The winner's address and write data are latched, and the L2 read data is registered and returned with a one-cycle response pulse. A saturating contention counter is exported for performance monitoring. Sits between the two L1 cache controllers and the L2 cache.

Parameters:
ADDR_WIDTH, 32, byte address width on all ports
LINE_WIDTH, 256, cache-line data width in bits
CNT_WIDTH, 16, width of the contention counter
D_FIRST, 1, tie-break winner after reset (1 = D-cache, 0 = I-cache)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
i_pmem_read  in  1  I-cache line fill request, held until i_pmem_resp
i_pmem_address  in  ADDR_WIDTH  I-cache fill address
i_pmem_rdata  out  LINE_WIDTH  fill data, valid while i_pmem_resp=1
i_pmem_resp  out  1  one-cycle completion pulse to I-cache
d_pmem_read  in  1  D-cache fill request, held until d_pmem_resp
d_pmem_write  in  1  D-cache writeback request, held until d_pmem_resp
d_pmem_address  in  ADDR_WIDTH  D-cache address
d_pmem_wdata  in  LINE_WIDTH  D-cache writeback data
d_pmem_rdata  out  LINE_WIDTH  fill data, valid while d_pmem_resp=1
d_pmem_resp  out  1  one-cycle completion pulse to D-cache
l2_read  out  1  L2 read strobe, held until l2_mem_resp
l2_write  out  1  L2 write strobe, held until l2_mem_resp
l2_address  out  ADDR_WIDTH  latched address of the granted request
l2_wdata  out  LINE_WIDTH  latched write data
l2_rdata  in  LINE_WIDTH  L2 read data, valid with l2_mem_resp
l2_mem_resp  in  1  L2 completion
grant_d  out  1  1 = D-cache currently owns L2 (status)
busy  out  1  1 = arbiter not in IDLE
contention_count  out  CNT_WIDTH  saturating count of loser-waiting cycles

Behaviour:
- Reset (rst=1 at a posedge): state=IDLE. All resp, strobe and status outputs are 0. rdata/address/wdata registers are 0. contention_count=0. last_grant=~D_FIRST. Reset mid-transaction abandons it with no response pulse, and L2 strobes drop on the next cycle.
- States:
  - IDLE: no strobes. Pending requests are d_req = d_pmem_read|d_pmem_write and i_req = i_pmem_read.
  - If only one requester is pending, it wins.
  - If both are pending, the requester that is not last_grant wins.
  - On a win: latch address (and d_pmem_wdata, plus the read/write type), update last_grant, and move to SERVE_I or SERVE_D.
- SERVE_I / SERVE_D:
  - l2_read / l2_write are driven from the latched type, registered and stable for the whole state.
  - On l2_mem_resp=1: capture l2_rdata into the line register and move to RESP_I / RESP_D.
- RESP_I / RESP_D: the matching *_pmem_resp is 1 for exactly one cycle, *_pmem_rdata equals the captured line, and the next state is IDLE. No strobes are driven. This dead cycle prevents a still-asserted request from being re-arbitrated.
- Latency:
  - Request at cycle 0 in IDLE gives a strobe from cycle 1.
  - l2_mem_resp at cycle N gives *_pmem_resp at N+1, and IDLE at N+2.
  - Minimum back-to-back spacing between grants is 3 cycles.
- If d_pmem_read and d_pmem_write are both 1, write takes precedence, and exactly one of l2_read/l2_write is ever 1.
- A request deasserted during SERVE is a protocol violation. The L2 transaction still completes and the response pulse is still issued.
- l2_mem_resp outside the SERVE states is ignored.
- *_pmem_rdata holds its last value outside RESP. Requesters must sample only on resp.
- contention_count increments by 1 each cycle in which a requester is pending but not granted (including all SERVE/RESP cycles of the other requester). It saturates at all-ones.
- grant_d=1 in SERVE_D and RESP_D only. busy=1 in every state except IDLE.

Decomposition:
- Package l2_arb_types holds:
  - the state enum (IDLE, SERVE_I, SERVE_D, RESP_I, RESP_D);
  - a requester enum (REQ_I, REQ_D) used for last_grant;
  - default width constants.
- One natural sub-module: sat_counter (parameterised width, inc, synchronous clear, saturating), used for contention_count.
- Arbitration and the datapath stay in the top module.

Test Plan:
- Single I fill: i_pmem_read=1 at 0x0000_1040 with L2 responding 4 cycles after l2_read rises, l2_rdata=0xAA..AA → l2_address=0x1040, i_pmem_resp pulses once with rdata 0xAA..AA, d_pmem_resp stays 0, contention_count=0.
- Simultaneous first requests after reset, D_FIRST=1: i_pmem_read and d_pmem_read both pending → D is served first, then I. In a continuous tie, grants alternate D, I, D, I.
- D writeback: d_pmem_write=1, address 0x0000_2000, wdata 0x1234…, inputs changed during SERVE_D → l2_write=1, l2_read=0, l2_address/l2_wdata hold the latched values until l2_mem_resp, then d_pmem_resp pulses once.
- Contention saturation with CNT_WIDTH=4: I held waiting while D is served for 20 cycles → contention_count stops at 15.
- Reset mid-operation: rst asserted in SERVE_D → next cycle l2_write=0, state IDLE, no d_pmem_resp pulse, contention_count=0. A late l2_mem_resp after reset is ignored.
- Spurious l2_mem_resp in IDLE with no requests → no response pulses, and the state stays IDLE.
